// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package encoder_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MAX_N      = 64;

    // More than one bit set exactly when clearing the lowest set bit leaves something behind.
    function automatic logic popcount_gt1(input logic [MAX_N-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational N-to-log2(N) encoder; the highest set index wins, idx=0 when nothing is set.
module prio_enc_core #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/prio_encoder_rr_pipe.sv
// Registered priority encoder with fixed or round-robin selection and a one-deep
// valid/ready output stage.
module prio_encoder_rr_pipe
    import encoder_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int MODE  = 0,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_multi
);

    logic [N-1:0]     req;
    logic             accept;
    logic [N-1:0]     core_vec;
    logic [IDX_W-1:0] core_idx;
    logic             core_any;
    logic [IDX_W-1:0] win_idx;

    assign req      = in_valid ? in_vec : '0;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    prio_enc_core #(.N(N)) u_core (
        .vec (core_vec),
        .idx (core_idx),
        .any (core_any)
    );

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [IDX_W-1:0] rr_ptr;
            logic [N-1:0]     rot;
            logic [IDX_W-1:0] offset;
            logic [IDX_W:0]   sum;

            // rot[k] = req[(rr_ptr + k) mod N]; reversing it turns the core's
            // highest-wins search into a lowest-k-first scan starting at rr_ptr.
            assign rot = N'({req, req} >> rr_ptr);
            for (genvar gi = 0; gi < N; gi++) begin : g_rev
                assign core_vec[gi] = rot[N-1-gi];
            end

            assign offset  = IDX_W'(N - 1) - core_idx;
            assign sum     = {1'b0, rr_ptr} + {1'b0, offset};
            assign win_idx = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                    : sum[IDX_W-1:0];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rr_ptr <= '0;
                end else if (accept && core_any) begin
                    rr_ptr <= (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + 1'b1;
                end
            end
        end else begin : g_fixed
            assign core_vec = req;
            assign win_idx  = core_idx;
        end
    endgenerate

    // A take without a new accept only drops out_valid; the payload is left as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_zero  <= 1'b0;
            out_multi <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_idx   <= core_any ? win_idx : '0;
            out_zero  <= !core_any;
            out_multi <= popcount_gt1(MAX_N'(req));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
